itch_msg_dispatcher: RTL and testbench
======================================

Name: itch_msg_dispatcher

Overview:
- Front-end stage of the ITCH decode chain; sits directly upstream of the per-message field parsers (order-delete, add-order).
- Registers the 64-bit packed message stream and finds each message type byte at the current bit offset.
- For 'A' and 'D' messages, hands the payload word and its bit offset to the matching parser, then waits for that parser's end indication.
- Handles 'T' (seconds) messages internally. Flags unknown types.

Parameters:
- TYPE_ADD, 8'h41, type code routed to the add-order parser.
- TYPE_DEL, 8'h44, type code routed to the order-delete parser.
- TYPE_SEC, 8'h54, seconds message, decoded internally (4 payload bytes).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_data  in  64  packed stream word; byte k = bits [8k+7:8k]
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid && in_ready
- data_out  out  64  current word (cur_word) shared with parsers
- data_out_valid  out  1  cur_word holds an accepted, unconsumed word
- start_add  out  1  add-order parser owns stream; level, held until par_end
- start_del  out  1  order-delete parser owns stream; level, held until par_end
- par_tracker  out  6  bit offset of first payload byte in data_out when a start first asserts
- par_end  in  1  active parser has consumed its last word this cycle
- par_next_off  in  7  bit offset (0..64, multiple of 8) of the next type byte in that last word; 64 = next word offset 0
- seconds  out  32  last 'T' payload, first byte in LSBs
- msg_count  out  16  messages dispatched or decoded, wraps at 65535->0
- type_err  out  1  sticky unknown-type flag

Behaviour:
- Reset (sync) values: state=S_LOAD, off=0, cur_valid=0, starts=0, par_tracker=0, seconds=0, msg_count=0, type_err=0, bytes_left=0. A reset mid-message discards all progress; the first word after reset is treated as holding a type byte at offset 0.
- cur_word loads in_data on acceptance. cur_valid=1 after an accept; it clears when in_ready=1 and in_valid=0.
- No state advances while cur_valid=0.
- S_LOAD:
  - in_ready=1.
  - Go to S_TYPE on accept.
- S_TYPE (cur_valid), with t = cur_word[off+7:off] and p = off+8:
  - t = TYPE_DEL or TYPE_ADD, p<64:
    - Assert the matching start in the same cycle with par_tracker=p.
    - in_ready=0. Go to S_BUSY.
  - t = TYPE_DEL or TYPE_ADD, p==64:
    - in_ready=1. Go to S_LAUNCH.
  - t = TYPE_SEC:
    - bytes_left=4, off=p mod 64.
    - If p==64: in_ready=1. Otherwise in_ready=0.
    - Go to S_TIME.
  - Any other value:
    - type_err=1. Go to S_ERR.
  - msg_count increments once per decoded known type.
- S_LAUNCH:
  - On the next accepted word, assert start with par_tracker=0 and in_ready=0.
  - Go to S_BUSY.
- S_BUSY:
  - Start level held.
  - in_ready=1 so the parser sees consecutive words.
  - On par_end, drop start the next cycle.
  - If par_next_off<64: off=par_next_off, in_ready=0 in the par_end cycle (combinational from par_end; the only input-to-output path), go to S_TYPE on the same word.
  - If par_next_off==64: off=0, go to S_LOAD.
  - par_end outside S_BUSY is ignored.
- S_TIME:
  - Per valid word, take n = min(bytes_left, (64-off)/8) bytes from offset off.
  - Write them into seconds at byte index 4-bytes_left.
  - bytes_left -= n.
  - While bytes_left>0 after the update: off=0, in_ready=1.
  - When bytes_left reaches 0: off+=8n. If off==64, go to S_LOAD with off=0. Otherwise go to S_TYPE with in_ready=0.
- S_ERR:
  - in_ready=0. All starts 0.
  - Held until rst.
- At most one start is high at any time.

Test Plan:
- Byte0=0x44, word accepted -> start_del=1 that cycle, par_tracker=8, in_ready=0, msg_count=1.
- Byte7=0x41 in word0, then word1 -> start_add rises in the word1 cycle with par_tracker=0. par_end with par_next_off=24 -> S_TYPE decodes byte3 of word1 next cycle; in_ready low during the par_end cycle.
- Byte6=0x54, byte7=0x78 in word0; bytes0-2 of word1 = 0x56,0x34,0x12, byte3=0x44 -> seconds=0x12345678, then start_del with par_tracker=32 on word1.
- par_end with par_next_off=64 -> in_ready stays 1, next word decoded at offset 0.
- Type byte 0x5A -> type_err=1 next cycle, in_ready=0, starts stay 0 for 20 cycles; rst clears type_err and msg_count.
- rst asserted in S_BUSY with start_del=1 -> next cycle start_del=0, data_out_valid=0, in_ready=1; the following word is decoded at offset 0.

Source files
------------

// File: rtl/itch_msg_dispatcher.sv
// ITCH front-end dispatcher: locates type bytes in the 64-bit word stream,
// hands 'A'/'D' messages to their parsers and decodes 'T' seconds inline.
module itch_msg_dispatcher #(
  parameter logic [7:0] TYPE_ADD = 8'h41,
  parameter logic [7:0] TYPE_DEL = 8'h44,
  parameter logic [7:0] TYPE_SEC = 8'h54
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] data_out,
  output logic        data_out_valid,
  output logic        start_add,
  output logic        start_del,
  output logic [5:0]  par_tracker,
  input  logic        par_end,
  input  logic [6:0]  par_next_off,
  output logic [31:0] seconds,
  output logic [15:0] msg_count,
  output logic        type_err
);

  localparam logic [2:0] S_LOAD   = 3'd0;
  localparam logic [2:0] S_TYPE   = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_BUSY   = 3'd3;
  localparam logic [2:0] S_TIME   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [5:0]  off_q, off_d;
  logic [63:0] cur_word_q, cur_word_d;
  logic        cur_valid_q, cur_valid_d;
  logic        start_add_q, start_add_d;
  logic        start_del_q, start_del_d;
  logic        launch_add_q, launch_add_d;
  logic [5:0]  par_tracker_q, par_tracker_d;
  logic [31:0] seconds_q, seconds_d;
  logic [15:0] msg_count_q, msg_count_d;
  logic        type_err_q, type_err_d;
  logic [2:0]  bytes_left_q, bytes_left_d;

  logic        ready_c, accept_c, add_now_c, del_now_c;
  logic [7:0]  type_byte_c;
  logic [6:0]  p_c, off_end_c;
  logic [2:0]  off_b_c, base_c, take_c, left_c, src_c;
  logic [3:0]  room_c;

  // Next-state, stream handshake and decode
  always_comb begin
    state_d       = state_q;
    off_d         = off_q;
    start_add_d   = start_add_q;
    start_del_d   = start_del_q;
    launch_add_d  = launch_add_q;
    par_tracker_d = par_tracker_q;
    seconds_d     = seconds_q;
    msg_count_d   = msg_count_q;
    type_err_d    = type_err_q;
    bytes_left_d  = bytes_left_q;
    ready_c       = 1'b0;
    add_now_c     = 1'b0;
    del_now_c     = 1'b0;
    src_c         = '0;

    type_byte_c = cur_word_q[off_q +: 8];
    p_c         = 7'(off_q) + 7'd8;
    off_b_c     = off_q[5:3];
    room_c      = 4'd8 - 4'(off_b_c);
    take_c      = (room_c > 4'(bytes_left_q)) ? bytes_left_q : room_c[2:0];
    left_c      = bytes_left_q - take_c;
    base_c      = 3'd4 - bytes_left_q;
    off_end_c   = 7'(off_q) + 7'({take_c, 3'b000});

    case (state_q)
      S_LOAD: begin
        // A word accepted while leaving the previous message is already waiting here
        ready_c = !cur_valid_q;
        if (cur_valid_q || in_valid) state_d = S_TYPE;
      end
      S_TYPE: begin
        if (!cur_valid_q) begin
          ready_c = 1'b1;
        end else if (type_byte_c == TYPE_ADD || type_byte_c == TYPE_DEL) begin
          msg_count_d = msg_count_q + 16'd1;
          if (p_c[6]) begin
            ready_c      = 1'b1;
            launch_add_d = (type_byte_c == TYPE_ADD);
            off_d        = '0;
            state_d      = S_LAUNCH;
          end else begin
            add_now_c     = (type_byte_c == TYPE_ADD);
            del_now_c     = (type_byte_c != TYPE_ADD);
            par_tracker_d = p_c[5:0];
            start_add_d   = add_now_c;
            start_del_d   = del_now_c;
            state_d       = S_BUSY;
          end
        end else if (type_byte_c == TYPE_SEC) begin
          msg_count_d  = msg_count_q + 16'd1;
          bytes_left_d = 3'd4;
          off_d        = p_c[5:0];
          ready_c      = p_c[6];
          state_d      = S_TIME;
        end else begin
          type_err_d = 1'b1;
          state_d    = S_ERR;
        end
      end
      S_LAUNCH: begin
        if (!cur_valid_q) begin
          ready_c = 1'b1;
        end else begin
          add_now_c     = launch_add_q;
          del_now_c     = !launch_add_q;
          par_tracker_d = '0;
          start_add_d   = add_now_c;
          start_del_d   = del_now_c;
          state_d       = S_BUSY;
        end
      end
      S_BUSY: begin
        ready_c = 1'b1;
        if (cur_valid_q && par_end) begin
          start_add_d = 1'b0;
          start_del_d = 1'b0;
          if (par_next_off[6]) begin
            off_d   = '0;
            state_d = S_LOAD;
          end else begin
            // Next type byte sits in this same word: hold it
            ready_c = 1'b0;
            off_d   = par_next_off[5:0];
            state_d = S_TYPE;
          end
        end
      end
      S_TIME: begin
        if (!cur_valid_q) begin
          ready_c = 1'b1;
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (3'(k) >= base_c && 3'(k) < base_c + take_c) begin
              src_c = off_b_c + (3'(k) - base_c);
              seconds_d[{k[1:0], 3'b000} +: 8] = cur_word_q[{src_c, 3'b000} +: 8];
            end
          end
          bytes_left_d = left_c;
          if (left_c != 3'd0) begin
            off_d   = '0;
            ready_c = 1'b1;
          end else if (off_end_c[6]) begin
            off_d   = '0;
            ready_c = 1'b1;
            state_d = S_LOAD;
          end else begin
            off_d   = off_end_c[5:0];
            state_d = S_TYPE;
          end
        end
      end
      S_ERR: begin
        ready_c = 1'b0;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase

    accept_c    = in_valid && ready_c;
    cur_word_d  = accept_c ? in_data : cur_word_q;
    cur_valid_d = accept_c ? 1'b1 : (ready_c ? 1'b0 : cur_valid_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_LOAD;
      off_q         <= '0;
      cur_word_q    <= '0;
      cur_valid_q   <= 1'b0;
      start_add_q   <= 1'b0;
      start_del_q   <= 1'b0;
      launch_add_q  <= 1'b0;
      par_tracker_q <= '0;
      seconds_q     <= '0;
      msg_count_q   <= '0;
      type_err_q    <= 1'b0;
      bytes_left_q  <= '0;
    end else begin
      state_q       <= state_d;
      off_q         <= off_d;
      cur_word_q    <= cur_word_d;
      cur_valid_q   <= cur_valid_d;
      start_add_q   <= start_add_d;
      start_del_q   <= start_del_d;
      launch_add_q  <= launch_add_d;
      par_tracker_q <= par_tracker_d;
      seconds_q     <= seconds_d;
      msg_count_q   <= msg_count_d;
      type_err_q    <= type_err_d;
      bytes_left_q  <= bytes_left_d;
    end
  end

  // Starts rise in the decode cycle itself, then hold from the registered level
  assign in_ready       = ready_c;
  assign data_out       = cur_word_q;
  assign data_out_valid = cur_valid_q;
  assign start_add      = start_add_q | add_now_c;
  assign start_del      = start_del_q | del_now_c;
  assign par_tracker    = (add_now_c || del_now_c) ? par_tracker_d : par_tracker_q;
  assign seconds        = seconds_q;
  assign msg_count      = msg_count_q;
  assign type_err       = type_err_q;

endmodule

// File: tb/tb_itch_msg_dispatcher.sv
// Bench for itch_msg_dispatcher: random ITCH byte stream with a parser stub,
// scoreboard of expected parser launches, plus directed reset/error cases.
module tb_itch_msg_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] data_out;
  logic        data_out_valid;
  logic        start_add;
  logic        start_del;
  logic [5:0]  par_tracker;
  logic        par_end;
  logic [6:0]  par_next_off;
  logic [31:0] seconds;
  logic [15:0] msg_count;
  logic        type_err;

  always #5 clk = ~clk;

  itch_msg_dispatcher dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .start_add(start_add),
    .start_del(start_del), .par_tracker(par_tracker), .par_end(par_end),
    .par_next_off(par_next_off), .seconds(seconds), .msg_count(msg_count),
    .type_err(type_err)
  );

  typedef struct { logic [7:0] typ; int word; logic [5:0] trk; logic [31:0] sec; } exp_t;
  typedef struct { int end_w; logic [6:0] next_off; } par_t;

  exp_t        exp_q[$];
  par_t        par_q[$];
  logic [7:0]  bytes_q[$];
  logic [63:0] words[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          n_msg = 0;
  logic [31:0] last_sec = '0;
  bit          auto_mode = 1'b0;
  int          cur_idx = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference stream: messages laid out back to back as bytes, then packed into words
  task automatic gen_stream(input int nm);
    int s, len, r, e, pick;
    logic [7:0]  typ;
    logic [31:0] v;
    exp_t ex;
    par_t pe;
    for (int m = 0; m < nm || (bytes_q.size() % 8) != 0; m++) begin
      s = bytes_q.size();
      r = (8 - s % 8) % 8;
      pick = (m >= nm) ? 1 : int'($urandom_range(0, 2));
      if (pick == 2) begin
        v = $urandom;
        bytes_q.push_back(8'h54);
        for (int k = 0; k < 4; k++) bytes_q.push_back(v[8*k +: 8]);
        last_sec = v;
      end else begin
        typ = (pick == 0) ? 8'h41 : 8'h44;
        if (m >= nm) len = (r >= 2) ? r : r + 8;
        else len = int'($urandom_range(2, 20));
        bytes_q.push_back(typ);
        for (int k = 1; k < len; k++) bytes_q.push_back(8'($urandom));
        ex.typ  = typ;
        ex.word = (s % 8 == 7) ? s / 8 + 1 : s / 8;
        ex.trk  = (s % 8 == 7) ? 6'd0 : 6'((s % 8 + 1) * 8);
        ex.sec  = last_sec;
        exp_q.push_back(ex);
        e = s + len;
        pe.end_w    = (e - 1) / 8;
        pe.next_off = 7'((e - 8 * pe.end_w) * 8);
        par_q.push_back(pe);
      end
      n_msg++;
    end
    for (int i = 0; i < bytes_q.size() / 8; i++) begin
      logic [63:0] w;
      for (int k = 0; k < 8; k++) w[8*k +: 8] = bytes_q[8*i + k];
      words.push_back(w);
    end
  endtask

  task automatic send_word(input logic [63:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compares each parser launch against the scoreboard
  initial begin
    bit   mon_active;
    exp_t e;
    mon_active = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (auto_mode) begin
        chk("one_start", 64'(start_add & start_del), 64'(0));
        if (!mon_active && (start_add || start_del)) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL unexpected_start: got add=%0b del=%0b expected no start", start_add, start_del);
          end else begin
            e = exp_q.pop_front();
            chk("start_kind", 64'({start_add, start_del}), 64'((e.typ == 8'h41) ? 2'b10 : 2'b01));
            chk("par_tracker", 64'(par_tracker), 64'(e.trk));
            chk("start_word", 64'(cur_idx), 64'(e.word));
            chk("seconds_at_start", 64'(seconds), 64'(e.sec));
          end
          mon_active = 1'b1;
        end else if (mon_active && par_end && data_out_valid) begin
          mon_active = 1'b0;
        end
      end else begin
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   wi, cyc, p_end_w;
    bit   p_active, acc;
    logic [6:0] p_next;
    par_t pp;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; par_end = 1'b0; par_next_off = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_outputs", 64'({data_out_valid, start_add, start_del, type_err}), 64'(0));
    chk("rst_tracker", 64'(par_tracker), 64'(0));
    chk("rst_seconds", 64'(seconds), 64'(0));
    chk("rst_count", 64'(msg_count), 64'(0));

    gen_stream(400);
    auto_mode = 1'b1;
    wi = 0; cyc = 0; p_active = 1'b0; p_end_w = 0; p_next = '0;
    while (!(wi == words.size() && !p_active && exp_q.size() == 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      par_end = 1'b0;
      if (!p_active && (start_add || start_del)) begin
        pp = par_q.pop_front();
        p_end_w  = pp.end_w;
        p_next   = pp.next_off;
        p_active = 1'b1;
      end else if (p_active && data_out_valid && cur_idx == p_end_w) begin
        par_end      = 1'b1;
        par_next_off = p_next;
      end
      if (wi < words.size() && $urandom_range(0, 9) < 7) begin
        in_valid = 1'b1;
        in_data  = words[wi];
      end else begin
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
      end
      #1;
      acc = in_valid && in_ready;
      if (par_end) chk("ready_at_par_end", 64'(in_ready), 64'(par_next_off == 7'd64));
      @(posedge clk);
      if (acc) begin
        cur_idx = wi;
        wi++;
      end
      if (par_end) p_active = 1'b0;
    end
    if (cyc >= 20000) chk("drain_timeout", 64'(cyc), 64'(0));
    #1;
    in_valid = 1'b0;
    par_end  = 1'b0;
    repeat (10) @(negedge clk);
    auto_mode = 1'b0;
    chk("final_count", 64'(msg_count), 64'(n_msg));
    chk("final_seconds", 64'(seconds), 64'(last_sec));
    chk("final_idle", 64'({type_err, data_out_valid, start_add, start_del, in_ready}), 64'(5'b00001));

    // Reset clears counters; 'D' at offset 0 of first word after reset
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("rst2_count", 64'(msg_count), 64'(0));
    chk("rst2_seconds", 64'(seconds), 64'(0));
    @(posedge clk); #1;
    send_word({$urandom, 24'($urandom), 8'h44});
    @(negedge clk);
    chk("del_start", 64'({start_add, start_del, in_ready}), 64'(3'b010));
    chk("del_tracker", 64'(par_tracker), 64'(8));
    @(negedge clk);
    chk("del_count", 64'(msg_count), 64'(1));
    chk("del_held", 64'(start_del), 64'(1));
    do_reset();
    @(negedge clk);
    chk("busy_rst", 64'({start_del, data_out_valid, in_ready}), 64'(3'b001));
    @(posedge clk); #1;
    send_word({8'h44, 48'($urandom), 8'h41});
    @(negedge clk);
    chk("post_rst_add", 64'({start_add, start_del}), 64'(2'b10));
    chk("post_rst_tracker", 64'(par_tracker), 64'(8));

    // Unknown type locks into error until reset
    do_reset();
    send_word({$urandom, 24'($urandom), 8'h5A});
    @(posedge clk);
    @(negedge clk);
    chk("err_flag", 64'({type_err, in_ready}), 64'(2'b10));
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom);
      par_end  = 1'($urandom);
      in_data  = {$urandom, $urandom};
      @(negedge clk);
      chk("err_hold", 64'({start_add, start_del, in_ready, type_err}), 64'(4'b0001));
    end
    in_valid = 1'b0;
    par_end  = 1'b0;
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("err_cleared", 64'({type_err, in_ready}), 64'(2'b01));
    chk("err_count_cleared", 64'(msg_count), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
